// File: rtl/mc_request_arbiter.sv
// Round-robin arbiter that shares one memory controller between NUM_REQ
// requesters. The winner's op/address/length are latched in IDLE and issued
// as a one-cycle mc_start. The grant is held until mc_done arrives or the
// watchdog runs out, in which case the MC is told to abort.
module mc_request_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 6,
    parameter int LEN_W   = 6,
    parameter int TIMEOUT = 64
) (
    input  logic                      ctrl_clk,
    input  logic                      ctrl_reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [3*NUM_REQ-1:0]      req_op,
    input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
    input  logic [LEN_W*NUM_REQ-1:0]  req_len,
    output logic [NUM_REQ-1:0]        req_grant,
    output logic [NUM_REQ-1:0]        req_done,
    output logic [NUM_REQ-1:0]        req_error,
    output logic                      mc_start,
    output logic [2:0]                mc_op,
    output logic [ADDR_W-1:0]         mc_addr,
    output logic [LEN_W-1:0]          mc_len,
    output logic                      mc_abort,
    input  logic                      mc_done
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, CHECK, WAIT, RELEASE} state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   owner;
    logic [WD_W-1:0]    wd;

    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [2:0]         win_op;
    logic [ADDR_W-1:0]  win_addr;
    logic [LEN_W-1:0]   win_len;

    logic               op_ok;
    logic               start_nxt, done_nxt, err_nxt, abort_nxt;

    // Winner search: first valid request after rr_ptr, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_op    = '0;
        win_addr  = '0;
        win_len   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int j;
            j = int'(rr_ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!win_found && req_valid[j]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(j);
                win_op    = req_op[j*3 +: 3];
                win_addr  = req_addr[j*ADDR_W +: ADDR_W];
                win_len   = req_len[j*LEN_W +: LEN_W];
            end
        end
    end

    assign op_ok = (mc_op == 3'b100) || (mc_op == 3'b010) || (mc_op == 3'b001);

    // State register.
    always_ff @(posedge ctrl_clk or posedge ctrl_reset) begin
        if (ctrl_reset) state <= IDLE;
        else            state <= state_nxt;
    end

    // Next state and the one-cycle strobes to be registered on this edge.
    always_comb begin
        state_nxt = state;
        start_nxt = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        abort_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (win_found) state_nxt = CHECK;
            end
            CHECK: begin
                if (!op_ok) begin
                    err_nxt   = 1'b1;
                    state_nxt = RELEASE;
                end else if (mc_len == '0) begin
                    done_nxt  = 1'b1;
                    state_nxt = RELEASE;
                end else begin
                    start_nxt = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                // A completion on the expiry cycle still counts as success.
                if (mc_done) begin
                    done_nxt  = 1'b1;
                    state_nxt = RELEASE;
                end else if (wd == WD_W'(TIMEOUT - 1)) begin
                    err_nxt   = 1'b1;
                    abort_nxt = 1'b1;
                    state_nxt = RELEASE;
                end
            end
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: grant/command latches, watchdog, rr pointer and output strobes.
    always_ff @(posedge ctrl_clk or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            req_grant <= '0;
            req_done  <= '0;
            req_error <= '0;
            mc_start  <= 1'b0;
            mc_abort  <= 1'b0;
            mc_op     <= '0;
            mc_addr   <= '0;
            mc_len    <= '0;
            wd        <= '0;
            owner     <= '0;
            rr_ptr    <= IDX_W'(NUM_REQ - 1);
        end else begin
            mc_start  <= start_nxt;
            mc_abort  <= abort_nxt;
            req_done  <= done_nxt ? req_grant : '0;
            req_error <= err_nxt  ? req_grant : '0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        owner     <= win_idx;
                        req_grant <= NUM_REQ'(1) << win_idx;
                        mc_op     <= win_op;
                        mc_addr   <= win_addr;
                        mc_len    <= win_len;
                    end
                end
                CHECK:   wd <= '0;
                WAIT:    wd <= wd + WD_W'(1);
                RELEASE: begin
                    req_grant <= '0;
                    mc_op     <= '0;
                    mc_addr   <= '0;
                    mc_len    <= '0;
                    wd        <= '0;
                    rr_ptr    <= owner;
                end
                default: ;
            endcase
        end
    end
endmodule
